reg_dump_sequencer: RTL

- Debug-unit controller that walks every entry of the pipeline register bank through one read port.
- Streams each word as bytes, least-significant byte first, over a valid/ready byte interface to the UART transmitter.
- Holds o_busy high for the whole dump so the debug unit keeps the pipeline halted and the bank contents stay stable.
- Sits between the debug-unit command FSM and the UART TX path.

---
 rtl/reg_dump_sequencer_if.sv | 25 ++
 rtl/reg_dump_sequencer.sv | 113 +++++++++++
 2 files changed

// File: rtl/reg_dump_sequencer_if.sv
// Byte-stream handshake between the register-dump sequencer and the UART
// transmitter.
//   tx_data  : byte offered to the transmitter
//   tx_valid : tx_data is valid; held until accepted
//   tx_ready : transmitter accepts the byte on this rising edge
// master = sequencer side, slave = transmitter side.
interface reg_dump_sequencer_if #(
  parameter int NB_BYTE = 8
);
  logic [NB_BYTE-1:0] tx_data;
  logic               tx_valid;
  logic               tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/reg_dump_sequencer.sv
// Debug-unit register dump sequencer.
// Walks all 2**NB_REG entries of the pipeline register bank through one read
// port. Each word is streamed as bytes, least-significant byte first, over a
// valid/ready byte interface to the UART transmitter. o_busy stays high for
// the whole dump so the pipeline stays halted and the bank stays stable.
// Ports:
//   i_clk       : system clock, rising edge
//   i_reset     : asynchronous, active-low reset; abandons any dump
//   i_start     : dump request, only honoured in IDLE
//   o_read_reg  : register bank read address (the word index)
//   i_reg_data  : combinational read data from the register bank
//   tx          : byte stream to the transmitter (master side)
//   o_busy      : dump in progress (LOAD, SEND, DONE)
//   o_done      : one-cycle pulse when the dump completes
module reg_dump_sequencer #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_BYTE = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_start,
  output logic [NB_REG-1:0]   o_read_reg,
  input  logic [NB_DATA-1:0]  i_reg_data,
  reg_dump_sequencer_if.master tx,
  output logic                o_busy,
  output logic                o_done
);

  localparam int NB_BYTES = NB_DATA / NB_BYTE;
  localparam int NB_CNT   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(NB_BYTES - 1);
  localparam logic [NB_REG-1:0] LAST_REG  = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [NB_REG-1:0]    reg_idx;
  logic [NB_REG-1:0]    reg_idx_next;
  logic [NB_CNT-1:0]    byte_cnt;
  logic [NB_CNT-1:0]    byte_cnt_next;
  logic [NB_DATA-1:0]   shift_reg;
  logic [NB_DATA-1:0]   shift_reg_next;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= ST_IDLE;
      reg_idx   <= '0;
      byte_cnt  <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_next;
      reg_idx   <= reg_idx_next;
      byte_cnt  <= byte_cnt_next;
      shift_reg <= shift_reg_next;
    end
  end

  // tx_valid is a pure decode of the state register, so a transfer in SEND
  // is simply tx_ready being high; there is no path from tx_ready to valid.
  always_comb begin
    state_next     = state;
    reg_idx_next   = reg_idx;
    byte_cnt_next  = byte_cnt;
    shift_reg_next = shift_reg;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          reg_idx_next = '0;
          state_next   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        shift_reg_next = i_reg_data;
        byte_cnt_next  = '0;
        state_next     = ST_SEND;
      end
      ST_SEND: begin
        if (tx.tx_ready) begin
          if (byte_cnt == LAST_BYTE) begin
            if (reg_idx == LAST_REG) begin
              state_next = ST_DONE;
            end else begin
              reg_idx_next = reg_idx + 1'b1;
              state_next   = ST_LOAD;
            end
          end else begin
            shift_reg_next = shift_reg >> NB_BYTE;
            byte_cnt_next  = byte_cnt + 1'b1;
          end
        end
      end
      ST_DONE: begin
        reg_idx_next = '0;
        state_next   = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign o_read_reg  = reg_idx;
  assign tx.tx_data  = shift_reg[NB_BYTE-1:0];
  assign tx.tx_valid = (state == ST_SEND);
  assign o_busy      = (state != ST_IDLE);
  assign o_done      = (state == ST_DONE);

endmodule
